// File: rtl/run_pkg.sv
// Shared definitions for the run expander: state encoding, default sizing
// and small decode helpers used by the FSM.
package run_pkg;

  localparam int DEF_LEN_W = 4;
  localparam int DEF_GAP   = 1;
  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  function automatic logic out_of(input state_t s);
    out_of = (s == ST_BURST);
  endfunction

  function automatic logic busy_of(input state_t s, input logic pend_valid);
    busy_of = (s != ST_IDLE) || pend_valid;
  endfunction

endpackage

// File: rtl/run_down_counter.sv
// Loadable down-counter with a zero flag; it holds at zero rather than
// wrapping, and load takes priority over decrement.
module run_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: load wins, decrement saturates at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != ZERO)) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == ZERO);

endmodule

// File: rtl/run_expander.sv
// Expands single-cycle trigger pulses into runs of 1s of programmable length,
// each followed by GAP forced-zero cycles, with a one-deep pending slot.
module run_expander
  import run_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [LEN_W-1:0] len,
  output logic             out,
  output logic             busy,
  output logic             overrun
);

  localparam logic [LEN_W-1:0]     LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]     LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP - 1);

  state_t           state_q;
  state_t           state_d;
  logic             pend_valid_q;
  logic             pend_valid_d;
  logic [LEN_W-1:0] pend_len_q;
  logic [LEN_W-1:0] pend_len_d;
  logic             overrun_q;
  logic             overrun_d;

  logic             trig_s;
  logic             run_load_s;
  logic [LEN_W-1:0] run_load_val_s;
  logic             run_dec_s;
  logic             run_zero_s;
  logic             gap_load_s;
  logic             gap_dec_s;
  logic             gap_zero_s;

  assign trig_s = in && (len != LEN_ZERO);

  run_down_counter #(.W(LEN_W)) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (run_load_s),
    .load_val (run_load_val_s),
    .dec      (run_dec_s),
    .zero     (run_zero_s)
  );

  run_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_s),
    .load_val (GAP_LOAD),
    .dec      (gap_dec_s),
    .zero     (gap_zero_s)
  );

  // next-state, pending slot and counter control
  always_comb begin
    state_d        = state_q;
    pend_valid_d   = pend_valid_q;
    pend_len_d     = pend_len_q;
    overrun_d      = 1'b0;
    run_load_s     = 1'b0;
    run_load_val_s = LEN_ZERO;
    run_dec_s      = 1'b0;
    gap_load_s     = 1'b0;
    gap_dec_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d        = ST_BURST;
          run_load_s     = 1'b1;
          run_load_val_s = len - LEN_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BURST: begin
        if (run_zero_s) begin
          state_d    = ST_GAP;
          gap_load_s = 1'b1;
        end else begin
          run_dec_s = 1'b1;
        end
        if (trig_s && !pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_len_d   = len;
        end else if (trig_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = 1'b0;
        end
      end

      ST_GAP: begin
        if (gap_zero_s && pend_valid_q) begin
          // pending run starts; a simultaneous trigger refills the freed slot
          state_d        = ST_BURST;
          run_load_s     = 1'b1;
          run_load_val_s = pend_len_q - LEN_ONE;
          pend_valid_d   = trig_s;
          if (trig_s) begin
            pend_len_d = len;
          end else begin
            pend_len_d = pend_len_q;
          end
        end else if (gap_zero_s && trig_s) begin
          state_d        = ST_BURST;
          run_load_s     = 1'b1;
          run_load_val_s = len - LEN_ONE;
        end else if (gap_zero_s) begin
          state_d = ST_IDLE;
        end else begin
          gap_dec_s = 1'b1;
          if (trig_s && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_len_d   = len;
          end else if (trig_s) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = 1'b0;
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // state, pending slot and overrun registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_len_q   <= LEN_ZERO;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_len_q   <= pend_len_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out     = out_of(state_q);
  assign busy    = busy_of(state_q, pend_valid_q);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_run_expander.sv
// Directed self-checking bench for run_expander (LEN_W=4, GAP=1).
module tb_run_expander;

  logic       clk;
  logic       reset;
  logic       in;
  logic [3:0] len;
  logic       out;
  logic       busy;
  logic       overrun;

  int n_assert;
  int n_fail;

  run_expander #(.LEN_W(4), .GAP(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .len     (len),
    .out     (out),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic eo, input logic eb, input logic ev);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".overrun"}, overrun, ev);
  endtask

  // drive inputs for one rising edge, then return on the following falling edge
  task automatic cyc(input logic i, input logic [3:0] l);
    in  = i;
    len = l;
    @(posedge clk);
    @(negedge clk);
    in  = 1'b0;
    len = 4'd0;
  endtask

  initial begin
    logic t3_out [8];
    logic t4_out [11];
    logic t5_out [10];
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    in       = 1'b0;
    len      = 4'd0;
    repeat (2) @(negedge clk);
    chk3("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk3("idle", 1'b0, 1'b0, 1'b0);

    // len=3 run: three 1s, one gap cycle, then idle
    cyc(1'b1, 4'd3); chk3("t1.c2", 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t1.c3", 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t1.c4", 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t1.c5", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t1.c6", 1'b0, 1'b0, 1'b0);

    // len=1 single pulse, then a len=0 trigger while idle
    cyc(1'b1, 4'd1); chk3("t2.run", 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t2.gap", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t2.idle", 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd0); chk3("t2.len0", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0); chk3("t2.after", 1'b0, 1'b0, 1'b0);

    // len=2 then len=4 queued during the burst
    t3_out = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 8; k++) begin
      if (k == 0) cyc(1'b1, 4'd2);
      else if (k == 1) cyc(1'b1, 4'd4);
      else cyc(1'b0, 4'd0);
      chk3($sformatf("t3.%0d", k), t3_out[k], 1'b1, 1'b0);
    end
    cyc(1'b0, 4'd0); chk3("t3.idle", 1'b0, 1'b0, 1'b0);

    // len=5, one queued trigger (len=3), one dropped trigger (len=2)
    t4_out = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 11; k++) begin
      if (k == 0) cyc(1'b1, 4'd5);
      else if (k == 1) cyc(1'b1, 4'd3);
      else if (k == 2) cyc(1'b1, 4'd2);
      else cyc(1'b0, 4'd0);
      chk3($sformatf("t4.%0d", k), t4_out[k], (k != 10), (k == 2));
    end

    // gap-end edge with pending valid and a new len=2 trigger
    t5_out = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (k == 0) cyc(1'b1, 4'd1);
      else if (k == 1) cyc(1'b1, 4'd3);
      else if (k == 2) cyc(1'b1, 4'd2);
      else cyc(1'b0, 4'd0);
      chk3($sformatf("t5.%0d", k), t5_out[k], (k != 9), 1'b0);
    end

    // async reset mid-run with a pending trigger
    cyc(1'b1, 4'd6); chk3("t6.c1", 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 4'd2); chk3("t6.c2", 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 chk3("t6.rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 4'd0);
      chk3($sformatf("t6.quiet%0d", k), 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 4'd2); chk3("t6.new1", 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t6.new2", 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t6.gap", 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0); chk3("t6.idle", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
